// File: rtl/interrupt_injector.sv
// ---------------------------------------------------------------------------
// interrupt_injector
//
// CPU-side receiving end of the interrupt instruction interface. The IO
// controller drives a 32-bit interrupt instruction word (0 = idle). Each new
// nonzero word is detected as one interrupt event and queued in a small FIFO.
// The fetch stage takes queued instructions through a show-ahead valid/ready
// handshake, so every event is injected into the pipeline exactly once.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, minimum 2)
//   PTR_W  pointer width, log2(DEPTH)
//
// Ports:
//   sysclk                 in   system clock, all state updates on posedge
//   reset                  in   asynchronous, active-low reset
//   interrupt_instruction  in   32-bit word from the input controller
//   int_enable             in   1 = queued interrupts may be presented
//   fetch_ready            in   fetch stage accepts an instruction this cycle
//   clear_overflow         in   synchronous clear of the overflow flag
//   inject_instr           out  head-of-queue instruction, 0 when not valid
//   inject_valid           out  inject_instr is valid
//   pending_count          out  number of queued entries, 0..DEPTH
//   overflow               out  sticky, an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module interrupt_injector #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [31:0]      interrupt_instruction,
  input  logic             int_enable,
  input  logic             fetch_ready,
  input  logic             clear_overflow,
  output logic [31:0]      inject_instr,
  output logic             inject_valid,
  output logic [PTR_W:0]   pending_count,
  output logic             overflow
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      last_word;
  logic             overflow_q;

  logic             push_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;

  // Event detection compares the live word against the word seen on the
  // previous edge, so a held word is one event while a change (or a return
  // through zero) is a new one. push_req only feeds state updates, so there
  // is no combinational path from the input word to the fetch-side outputs.
  always_comb begin
    push_req   = (interrupt_instruction != 32'd0) &&
                 (interrupt_instruction != last_word);
    fifo_full  = (count == FULL_COUNT);
    fifo_empty = (count == '0);
    inject_valid = !fifo_empty && int_enable;
    pop  = inject_valid && fetch_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // accept the new event without dropping it.
    push = push_req && (!fifo_full || pop);
    drop = push_req && fifo_full && !pop;
  end

  always_comb begin
    inject_instr = 32'd0;
    if (inject_valid) begin
      inject_instr = fifo_mem[rd_ptr];
    end
  end

  // Storage array; contents are only ever observed through inject_instr,
  // which is masked while the queue is empty, so no reset is needed here.
  always_ff @(posedge sysclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= interrupt_instruction;
    end
  end

  // Pointers and occupancy. Full/empty come from the count register, which
  // lets the pointers wrap naturally at DEPTH.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= 32'd0;
    end else begin
      last_word <= interrupt_instruction;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign pending_count = count;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_interrupt_injector.sv
// ---------------------------------------------------------------------------
// tb_interrupt_injector
//
// Directed, self-checking bench for interrupt_injector (DEPTH = 4). Inputs
// are driven just after a rising edge and outputs are sampled 1 time unit
// after the edge, so every check sees settled post-edge state.
// ---------------------------------------------------------------------------
module tb_interrupt_injector;

  logic        sysclk;
  logic        reset;
  logic [31:0] interrupt_instruction;
  logic        int_enable;
  logic        fetch_ready;
  logic        clear_overflow;
  logic [31:0] inject_instr;
  logic        inject_valid;
  logic [2:0]  pending_count;
  logic        overflow;

  int total_checks = 0;
  int bad_checks   = 0;

  interrupt_injector #(
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .sysclk                (sysclk),
    .reset                 (reset),
    .interrupt_instruction (interrupt_instruction),
    .int_enable            (int_enable),
    .fetch_ready           (fetch_ready),
    .clear_overflow        (clear_overflow),
    .inject_instr          (inject_instr),
    .inject_valid          (inject_valid),
    .pending_count         (pending_count),
    .overflow              (overflow)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) else begin
      bad_checks++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_word(input logic [31:0] word);
    interrupt_instruction = word;
    tick();
  endtask

  logic [31:0] round_words [4];
  logic [31:0] new_word;

  initial begin
    reset                 = 1'b0;
    interrupt_instruction = 32'd0;
    int_enable            = 1'b0;
    fetch_ready           = 1'b0;
    clear_overflow        = 1'b0;
    #12;
    reset = 1'b1;
    #1;

    // Reset state
    check_output("rst_valid", {31'd0, inject_valid}, 32'd0);
    check_output("rst_instr", inject_instr, 32'd0);
    check_output("rst_count", {29'd0, pending_count}, 32'd0);
    check_output("rst_ovf",   {31'd0, overflow}, 32'd0);

    // 1: single-cycle word, immediate delivery and pop
    int_enable  = 1'b1;
    fetch_ready = 1'b1;
    apply_word(32'h0000_00A1);
    check_output("t1_valid", {31'd0, inject_valid}, 32'd1);
    check_output("t1_instr", inject_instr, 32'h0000_00A1);
    apply_word(32'd0);
    check_output("t1_valid_after", {31'd0, inject_valid}, 32'd0);
    check_output("t1_count_after", {29'd0, pending_count}, 32'd0);

    // 2: held word is one event
    fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) apply_word(32'h0000_00A1);
    check_output("t2_count", {29'd0, pending_count}, 32'd1);
    check_output("t2_instr", inject_instr, 32'h0000_00A1);
    fetch_ready = 1'b1;
    apply_word(32'd0);
    check_output("t2_drained", {29'd0, pending_count}, 32'd0);

    // 3: back-to-back distinct words, in-order delivery
    fetch_ready = 1'b0;
    apply_word(32'h0000_00A1);
    apply_word(32'h0000_00B2);
    interrupt_instruction = 32'd0;
    check_output("t3_count", {29'd0, pending_count}, 32'd2);
    check_output("t3_head_a1", inject_instr, 32'h0000_00A1);
    fetch_ready = 1'b1;
    tick();
    check_output("t3_head_b2", inject_instr, 32'h0000_00B2);
    check_output("t3_count_1", {29'd0, pending_count}, 32'd1);
    tick();
    check_output("t3_empty", {31'd0, inject_valid}, 32'd0);

    // 4: overflow with int_enable low, clear, then ordered drain
    int_enable  = 1'b0;
    fetch_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      apply_word(32'h11 * i);
      apply_word(32'd0);
    end
    check_output("t4_count", {29'd0, pending_count}, 32'd4);
    check_output("t4_ovf",   {31'd0, overflow}, 32'd1);
    check_output("t4_valid_disabled", {31'd0, inject_valid}, 32'd0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_output("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
    int_enable  = 1'b1;
    fetch_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check_output("t4_drain", inject_instr, 32'h11 * i);
      tick();
    end
    check_output("t4_no_fifth", {29'd0, pending_count}, 32'd0);

    // 5: push during pop on a full FIFO, three rounds for pointer wrap
    for (int r = 0; r < 3; r++) begin
      int_enable  = 1'b0;
      fetch_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        round_words[i] = 32'h1000 + 32'(r * 16 + i + 1);
        apply_word(round_words[i]);
        apply_word(32'd0);
      end
      new_word = 32'h2000 + 32'(r + 1);
      check_output("t5_full", {29'd0, pending_count}, 32'd4);
      int_enable  = 1'b1;
      fetch_ready = 1'b1;
      apply_word(new_word);
      interrupt_instruction = 32'd0;
      check_output("t5_count_kept", {29'd0, pending_count}, 32'd4);
      check_output("t5_no_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 1; i < 4; i++) begin
        check_output("t5_order", inject_instr, round_words[i]);
        tick();
      end
      check_output("t5_new_last", inject_instr, new_word);
      tick();
      check_output("t5_empty", {29'd0, pending_count}, 32'd0);
    end

    // 6: asynchronous reset with 3 entries queued and overflow set
    int_enable  = 1'b0;
    fetch_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      apply_word(32'h300 + 32'(i));
      apply_word(32'd0);
    end
    int_enable  = 1'b1;
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check_output("t6_count_3", {29'd0, pending_count}, 32'd3);
    check_output("t6_ovf_set", {31'd0, overflow}, 32'd1);
    check_output("t6_head", inject_instr, 32'h302);
    #2;
    reset = 1'b0;
    #1;
    check_output("t6_rst_valid", {31'd0, inject_valid}, 32'd0);
    check_output("t6_rst_instr", inject_instr, 32'd0);
    check_output("t6_rst_count", {29'd0, pending_count}, 32'd0);
    check_output("t6_rst_ovf",   {31'd0, overflow}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check_output("t6_post_count", {29'd0, pending_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
